// File: rtl/wm8731_adc_receiver.sv
// WM8731 ADC capture path: I2S master clocks (BCLK/ADCLRC), 16-bit L/R deserialiser, valid/ready output.
// Optional WM8731_ADC_MONO_EN adds mono_dat = (L+R)>>>1, loaded together with the pair.
`timescale 1ns/1ps
module wm8731_adc_receiver #(
  parameter int BCLK_DIV    = 4,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   adc_dat,
  output logic                   bclk,
  output logic                   adc_lr_ck,
  output logic [SAMPLE_BITS-1:0] left_dat,
  output logic [SAMPLE_BITS-1:0] right_dat,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
`ifdef WM8731_ADC_MONO_EN
  ,
  output logic [SAMPLE_BITS-1:0] mono_dat
`endif
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  logic                   dat_s1_q, dat_s1_d;
  logic                   dat_s2_q, dat_s2_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic                   bclk_q, bclk_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   lr_q, lr_d;
  logic [SAMPLE_BITS-1:0] shl_q, shl_d;
  logic [SAMPLE_BITS-1:0] shr_q, shr_d;
  logic                   done_q, done_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [SAMPLE_BITS-1:0] right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   ovr_q, ovr_d;

  logic                   wrap;
  logic                   rise;
  logic                   fall;
  logic                   in_right;
  logic [BIT_W-1:0]       slot_k;
  logic                   capture;

  always_comb begin
    dat_s1_d  = adc_dat;
    dat_s2_d  = dat_s1_q;
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lr_d      = lr_q;
    shl_d     = shl_q;
    shr_d     = shr_q;
    done_d    = 1'b0;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    wrap     = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    rise     = wrap & ~bclk_q;
    fall     = wrap & bclk_q;
    in_right = (bit_cnt_q >= BIT_W'(SLOT_BITS));
    slot_k   = in_right ? (bit_cnt_q - BIT_W'(SLOT_BITS)) : bit_cnt_q;
    capture  = rise && (slot_k >= BIT_W'(1)) && (slot_k <= BIT_W'(SAMPLE_BITS));

    if (enable) begin
      div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
      if (wrap) bclk_d = ~bclk_q;
      if (fall) begin
        bit_cnt_d = (bit_cnt_q == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
        lr_d      = (bit_cnt_d >= BIT_W'(SLOT_BITS));
      end
      // MSB arrives at slot bit 1 (one BCLK after ADCLRC edge, I2S alignment)
      if (capture) begin
        if (in_right) shr_d = {shr_q[SAMPLE_BITS-2:0], dat_s2_q};
        else          shl_d = {shl_q[SAMPLE_BITS-2:0], dat_s2_q};
      end
      done_d = rise && in_right && (slot_k == BIT_W'(SAMPLE_BITS));
    end else begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      bit_cnt_d = '0;
      lr_d      = 1'b0;
      shl_d     = '0;
      shr_d     = '0;
      ovr_d     = 1'b0;
    end

    // Output pair register: a fresh pair always wins over an acceptance in the same cycle
    if (done_q) begin
      left_d  = shl_q;
      right_d = shr_q;
      valid_d = 1'b1;
      if (valid_q && !sample_ready && enable) ovr_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lr_q      <= 1'b0;
      shl_q     <= '0;
      shr_q     <= '0;
      done_q    <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      dat_s1_q  <= dat_s1_d;
      dat_s2_q  <= dat_s2_d;
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lr_q      <= lr_d;
      shl_q     <= shl_d;
      shr_q     <= shr_d;
      done_q    <= done_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bclk         = bclk_q;
  assign adc_lr_ck    = lr_q;
  assign left_dat     = left_q;
  assign right_dat    = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

`ifdef WM8731_ADC_MONO_EN
  logic [SAMPLE_BITS:0]   mono_sum;
  logic [SAMPLE_BITS-1:0] mono_q, mono_d;

  // One extra bit keeps the sign of the sum before the arithmetic halving
  always_comb begin
    mono_sum = {shl_q[SAMPLE_BITS-1], shl_q} + {shr_q[SAMPLE_BITS-1], shr_q};
    mono_d   = mono_q;
    if (done_q) mono_d = SAMPLE_BITS'(mono_sum >> 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mono_q <= '0;
    else          mono_q <= mono_d;
  end

  assign mono_dat = mono_q;
`endif

endmodule
